// File: rtl/sample_averager.sv
// Two-channel ADC sample averager with offset-binary DAC output and a valid/ready output register; optional rounding via SAMPLE_AVERAGER_ROUND_EN.
// Latency: one cycle from the IN_VALID of a window's last sample to OUT_VALID and the new codes.
// Backpressure: the result is held until OUT_READY; a result completed while held is dropped and raises sticky OVERRUN.
module sample_averager #(
   parameter int LOG2_N = 2
) (
   input  logic        CLK_50M,
   input  logic        RST_N,
   input  logic        ENABLE,
   input  logic        IN_VALID,
   input  logic [27:0] Va_Vb,
   input  logic        OUT_READY,
   output logic        OUT_VALID,
   output logic [11:0] Va_dac,
   output logic [11:0] Vb_dac,
   output logic        OVERRUN
);

   localparam logic [4:0] WIN_LEN = 5'(1 << LOG2_N);
   localparam int         SHIFT   = LOG2_N + 2;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state_q, state_d;
   logic signed [17:0] acc_a_q, acc_a_d;
   logic signed [17:0] acc_b_q, acc_b_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [11:0]        va_q, va_d;
   logic [11:0]        vb_q, vb_d;
   logic               ovr_q, ovr_d;

   logic               fire;
   logic               done;
   logic               xfer;
   logic               load;
   logic [4:0]         cnt_inc;
   logic signed [17:0] sum_a, sum_b;

   // Scale a complete window sum down to 12 bits and flip the sign bit for offset binary.
   function automatic logic [11:0] to_code(input logic signed [17:0] s);
`ifdef SAMPLE_AVERAGER_ROUND_EN
      logic signed [18:0] biased;
      logic signed [18:0] r;
      // One extra bit of headroom: a full-scale positive sum plus the half-LSB bias exceeds 18 bits.
      biased = 19'(s) + 19'(1 << (SHIFT - 1));
      r      = biased >>> SHIFT;
      if (r > 19'sd2047) begin
         return 12'hFFF;
      end
      return r[11:0] ^ 12'h800;
`else
      return 12'(s >>> SHIFT) ^ 12'h800;
`endif
   endfunction

   // The current sample is folded in combinationally so the final sample of a window counts in its own cycle.
   assign fire    = ENABLE & IN_VALID;
   assign sum_a   = acc_a_q + {{4{Va_Vb[27]}}, Va_Vb[27:14]};
   assign sum_b   = acc_b_q + {{4{Va_Vb[13]}}, Va_Vb[13:0]};
   assign cnt_inc = cnt_q + 5'd1;
   assign done    = fire && (cnt_inc == WIN_LEN);
   assign xfer    = (state_q == FULL) && OUT_READY;
   assign load    = done && ((state_q == EMPTY) || OUT_READY);

   assign OUT_VALID = (state_q == FULL);
   assign Va_dac    = va_q;
   assign Vb_dac    = vb_q;
   assign OVERRUN   = ovr_q;

   // Next-state logic for the accumulators, output register and EMPTY/FULL handshake state.
   always_comb begin
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      cnt_d   = cnt_q;
      va_d    = va_q;
      vb_d    = vb_q;
      ovr_d   = ovr_q;
      state_d = state_q;

      if (!ENABLE) begin
         acc_a_d = '0;
         acc_b_d = '0;
         cnt_d   = '0;
      end else if (IN_VALID) begin
         if (done) begin
            acc_a_d = '0;
            acc_b_d = '0;
            cnt_d   = '0;
         end else begin
            acc_a_d = sum_a;
            acc_b_d = sum_b;
            cnt_d   = cnt_inc;
         end
      end

      if (load) begin
         va_d = to_code(sum_a);
         vb_d = to_code(sum_b);
      end

      // Held result not yet taken: the new one is lost and the loss is remembered.
      if (done && (state_q == FULL) && !OUT_READY) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         EMPTY:   if (done) state_d = FULL;
         FULL:    if (xfer && !done) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // State registers with asynchronous reset to an empty window and mid-scale DAC codes.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         acc_a_q <= '0;
         acc_b_q <= '0;
         cnt_q   <= '0;
         va_q    <= 12'h800;
         vb_q    <= 12'h800;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_a_q <= acc_a_d;
         acc_b_q <= acc_b_d;
         cnt_q   <= cnt_d;
         va_q    <= va_d;
         vb_q    <= vb_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule
